// File: rtl/nibble_unloader.sv
// nibble_unloader: serializes 32-bit arch result words into 4-bit nibbles.
// A one-word holding register keeps back-to-back words streaming without a bubble.
module nibble_unloader #(
    parameter int NIBBLES = 8,
    parameter int W       = 4,
    parameter int IDX_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NIBBLES*W-1:0] word_in,
    input  logic               word_valid,
    output logic               word_ready,
    input  logic               enable,
    output logic [W-1:0]       data_out,
    output logic               out_valid,
    output logic [IDX_W-1:0]   out_idx,
    output logic               last,
    output logic [7:0]         word_count
);

    localparam int WORD_W = NIBBLES * W;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    typedef enum logic {
        EMPTY,
        SHIFT
    } state_t;

    state_t             state_q, state_d;
    logic [WORD_W-1:0]  sr_q, sr_d;
    logic [WORD_W-1:0]  hr_q, hr_d;
    logic               hold_q, hold_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         cnt_q, cnt_d;

    logic accept;
    logic xfer;
    logic at_last;

    assign word_ready = !rst && !hold_q;
    assign accept     = word_valid && word_ready;
    assign out_valid  = (state_q == SHIFT);
    assign xfer       = out_valid && enable;
    assign at_last    = (idx_q == IDX_LAST);
    assign last       = out_valid && at_last;
    assign data_out   = sr_q[W-1:0];
    assign out_idx    = idx_q;
    assign word_count = cnt_q;

    always_ff @(posedge clk) begin
        hr_q <= hr_d;
        if (rst) begin
            state_q <= EMPTY;
            sr_q    <= '0;
            hold_q  <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        hr_d    = hr_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    sr_d    = word_in;
                    idx_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (xfer && at_last) begin
                    cnt_d = cnt_q + 8'd1;
                    idx_d = '0;
                    if (hold_q) begin
                        sr_d   = hr_q;
                        hold_d = 1'b0;
                        if (accept) begin
                            hr_d   = word_in;
                            hold_d = 1'b1;
                        end
                    end else if (accept) begin
                        sr_d = word_in;
                    end else begin
                        // Clearing SR makes data_out read zero while idle.
                        sr_d    = '0;
                        state_d = EMPTY;
                    end
                end else begin
                    if (xfer) begin
                        sr_d  = sr_q >> W;
                        idx_d = idx_q + 1'b1;
                    end
                    if (accept) begin
                        hr_d   = word_in;
                        hold_d = 1'b1;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

endmodule

// File: tb/tb_nibble_unloader.sv
// Directed bench for nibble_unloader with a nibble-queue scoreboard.
// Every cycle the outputs are compared against the queue-based expectation.
module tb_nibble_unloader;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] word_in;
    logic        word_valid;
    logic        word_ready;
    logic        enable;
    logic [3:0]  data_out;
    logic        out_valid;
    logic [2:0]  out_idx;
    logic        last;
    logic [7:0]  word_count;

    int checks = 0;
    int errors = 0;

    logic [3:0] q[$];
    int e_idx = 0;
    int e_cnt = 0;

    nibble_unloader #(.NIBBLES(8), .W(4), .IDX_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .enable     (enable),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .out_idx    (out_idx),
        .last       (last),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(output bit acc);
        int n;
        bit e_ready;
        bit xfer;
        logic [3:0] e_data;
        #2;
        n = q.size();
        e_ready = !rst && !(n > 8 - e_idx);
        e_data = 4'h0;
        if (n != 0) e_data = q[0];
        chk("out_valid", out_valid, n != 0);
        chk("data_out", data_out, e_data);
        chk("out_idx", out_idx, e_idx);
        chk("last", last, (n != 0) && (e_idx == 7));
        chk("word_ready", word_ready, e_ready);
        chk("word_count", word_count, e_cnt);
        acc = word_valid && e_ready;
        xfer = (n != 0) && enable;
        if (rst) begin
            q.delete();
            e_idx = 0;
            e_cnt = 0;
        end else begin
            if (xfer) begin
                void'(q.pop_front());
                if (e_idx == 7) begin
                    e_idx = 0;
                    e_cnt = (e_cnt + 1) % 256;
                end else begin
                    e_idx++;
                end
            end
            if (acc)
                for (int k = 0; k < 8; k++)
                    q.push_back(word_in[k*4 +: 4]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        bit a;
        int k;
        word_in = w;
        word_valid = 1'b1;
        k = 0;
        do begin
            tick(a);
            k++;
        end while (!a && k < 100);
        if (!a) chk("send_timeout", 0, 1);
        word_valid = 1'b0;
    endtask

    task automatic drain(input bit stall);
        bit a;
        int k;
        k = 0;
        while (q.size() != 0 && k < 400) begin
            if (stall) enable = (k % 4 == 0) || (k % 4 == 3);
            else enable = 1'b1;
            tick(a);
            k++;
        end
        if (q.size() != 0) chk("drain_timeout", q.size(), 0);
        enable = 1'b1;
        tick(a);
    endtask

    initial begin
        bit a;
        rst = 1'b1;
        word_in = '0;
        word_valid = 1'b0;
        enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick(a);

        send(32'h76543210);
        drain(1'b0);
        chk("single_count", word_count, 1);

        send(32'hFEDCBA98);
        send(32'h01234567);
        drain(1'b0);
        chk("b2b_count", word_count, 3);

        word_in = 32'h89ABCDEF;
        word_valid = 1'b1;
        tick(a);
        word_valid = 1'b0;
        drain(1'b1);
        chk("stall_count", word_count, 4);

        send(32'hAAAA3210);
        tick(a);
        tick(a);
        chk("hold_idx2", out_idx, 2);
        send(32'hBBBB7654);
        send(32'hCCCCBA98);
        drain(1'b0);
        chk("hold_count", word_count, 7);

        send(32'h11111111);
        send(32'h22222222);
        repeat (3) tick(a);
        chk("mid_idx4", out_idx, 4);
        chk("mid_hold", word_ready, 0);
        rst = 1'b1;
        tick(a);
        rst = 1'b0;
        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_ready", word_ready, 1);
        chk("rst_count", word_count, 0);
        #1;
        send(32'h13579BDF);
        drain(1'b0);
        chk("post_rst_count", word_count, 1);

        rst = 1'b1;
        tick(a);
        rst = 1'b0;
        for (int i = 0; i < 255; i++)
            send(32'h01010101 * i + 32'h10203040);
        drain(1'b0);
        chk("wrap_255", word_count, 255);
        send(32'hDEADBEEF);
        drain(1'b0);
        chk("wrap_0", word_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
